fft_bf_sequencer: RTL and testbench
===================================

# fft_bf_sequencer

In-place radix-2 decimation-in-frequency (DIF) FFT sequencer that drives the shared butterfly datapath.

- Generates, per stage, the operand-pair read addresses, twiddle ROM index and delayed write-back addresses for an N-point buffer held in a dual-port memory.
- Sits between the frame buffer and the butterfly/twiddle-multiply pipeline in the FFT front end of the log-mel chain.
- Issues one butterfly per cycle and drains the pipeline between stages to avoid read-after-write hazards.

## Interface
Parameters:
- LOG_N, 6, log2 of transform size N (N = 2^LOG_N); legal 2..12
- LAT, 3, cycles from rd_en to matching wr_en (memory read + butterfly + twiddle multiply); legal 1..16

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high; one clock with reset high fully resets the block
- start  in  1  pulse; begins a transform when idle
- stall  in  1  freezes read issue (only with FFT_SEQ_STALL_EN)
- rd_en  out  1  read operand pair this cycle
- rd_addr0, rd_addr1  out  LOG_N  operand addresses
- tw_addr  out  LOG_N-1  twiddle index, aligned with rd_en
- wr_en  out  1  write back result pair this cycle
- wr_addr0, wr_addr1  out  LOG_N  write-back addresses
- stage  out  bits for 0..LOG_N-1  current stage index
- busy  out  1  transform in progress
- done  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start → RUN with stage=0, k=0.
  - RUN: issue butterfly k, then k++. After k=N/2-1 → DRAIN.
  - DRAIN: hold for LAT cycles. Then go to RUN with stage+1 and k=0, or to DONE if stage=LOG_N-1.
  - DONE: lasts one cycle, then IDLE.
- Address generation for stage s, butterfly k:
  - span = N>>(s+1)
  - j = k & (span-1)
  - grp = k >> (LOG_N-1-s)
  - rd_addr0 = (grp<<(LOG_N-s)) | j
  - rd_addr1 = rd_addr0 + span
  - tw_addr = j<<s
  - All arithmetic is unsigned, width LOG_N. Widths and address ranges never wrap.
- Write-back uses a LAT-deep shift register carrying {valid, addr0, addr1}.
  - wr_en/wr_addr0/wr_addr1 equal the rd_en/rd_addr0/rd_addr1 values from LAT cycles earlier.
  - Writes are in place: same addresses as the read.
- start while busy is ignored.
- start on the same cycle as reset is ignored.
- Reset mid-transform:
  - FSM returns to IDLE and the delay line is cleared.
  - No wr_en is asserted on any cycle after reset, including for in-flight reads.
- Output order is bit-reversed. Reordering is out of scope.

## Timing
- Reset values:
  - rd_en=0, wr_en=0, busy=0, done=0, stage=0
  - All address outputs 0
- Outputs are registered. rd_* outputs are 0 whenever rd_en=0.
- Start, stage and done cycles (start sampled high in IDLE at cycle 0):
  - First rd_en at cycle 1.
  - Each stage occupies N/2 + LAT cycles.
  - The first read of stage s+1 occurs on the cycle after the last wr_en of stage s.
  - done pulses at cycle 1 + LOG_N·(N/2+LAT).
- busy is high from cycle 1 through the done cycle inclusive.
- stage updates on the cycle of the stage's first rd_en.
- A new start is accepted on the cycle after done (IDLE).

## Configuration
- FFT_SEQ_STALL_EN defined:
  - stall=1 in RUN suppresses rd_en and holds k. The delay line keeps shifting, so in-flight writes still complete.
  - The DRAIN counter starts after the last actual read.
  - stall has no effect in DRAIN, DONE or IDLE.
- FFT_SEQ_STALL_EN undefined:
  - stall is ignored.
  - Timing is exactly as given in Timing.

## Test plan
All scenarios use LOG_N=3, LAT=3.
- Basic transform: start at cycle 0.
  - Stage 0 reads at cycles 1-4: pairs (0,4),(1,5),(2,6),(3,7), tw 0,1,2,3.
  - Stage 1 reads at cycles 8-11: (0,2),(1,3),(4,6),(5,7), tw 0,2,0,2.
  - Stage 2 reads at cycles 15-18: (0,1),(2,3),(4,5),(6,7), tw 0.
  - done at cycle 22.
- Write-back alignment: every wr_en/wr_addr equals the rd values 3 cycles earlier. Last wr_en at cycle 21. Zero cycles with rd_en and wr_en to the same address while the write is pending.
- start asserted at cycles 5 and 22 (while busy) → ignored. start at cycle 23 → new transform, first rd_en at 24.
- reset at cycle 10, then idle → no wr_en from cycle 11 onward; busy=0 and all outputs at reset values; next start behaves as in the basic transform.
- With FFT_SEQ_STALL_EN, stall high cycles 2-3 → stage 0 reads at cycles 1,4,5,6; stage 1 first read at cycle 10; done at cycle 24.
- Without FFT_SEQ_STALL_EN, same stall → identical to the basic transform.

Source files
------------

// File: rtl/fft_bf_sequencer.sv
// Radix-2 DIF FFT address sequencer: one butterfly per cycle, LAT-deep write-back delay, drain between stages.
// Optional FFT_SEQ_STALL_EN lets stall_i freeze read issue in RUN; otherwise stall_i is ignored.
module fft_bf_sequencer #(
    parameter int LOG_N = 6,
    parameter int LAT   = 3
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic                       start_i,
    input  logic                       stall_i,
    output logic                       rd_en_o,
    output logic [LOG_N-1:0]           rd_addr0_o,
    output logic [LOG_N-1:0]           rd_addr1_o,
    output logic [LOG_N-2:0]           tw_addr_o,
    output logic                       wr_en_o,
    output logic [LOG_N-1:0]           wr_addr0_o,
    output logic [LOG_N-1:0]           wr_addr1_o,
    output logic [$clog2(LOG_N)-1:0]   stage_o,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int KW  = LOG_N - 1;
    localparam int SW  = $clog2(LOG_N);
    localparam int SHW = SW + 1;
    localparam int CW  = 5;
    localparam int DW  = 2 * LOG_N + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [SW-1:0]   stage_q, stage_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            stall_eff;

    logic            rd_en_q, rd_en_d;
    logic [LOG_N-1:0] rd_addr0_q, rd_addr0_d;
    logic [LOG_N-1:0] rd_addr1_q, rd_addr1_d;
    logic [KW-1:0]   tw_addr_q, tw_addr_d;
    logic [SW-1:0]   stage_out_q, stage_out_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // Each entry is {valid, addr0, addr1}; entry LAT-1 drives the write port.
    logic [DW-1:0]   dly_q [LAT];

`ifdef FFT_SEQ_STALL_EN
    assign stall_eff = stall_i;
`else
    logic unused_stall;
    assign unused_stall = stall_i;
    assign stall_eff    = 1'b0;
`endif

    logic [SHW-1:0]   sh_grp, sh_base;
    logic [LOG_N-1:0] k_ext, span, jj, grp, base, addr0, addr1;
    logic [KW-1:0]    tw;

    always_comb begin
        sh_grp  = SHW'(LOG_N - 1) - SHW'(stage_q);
        sh_base = sh_grp + SHW'(1);
        k_ext   = {1'b0, k_q};
        span    = LOG_N'(1) << sh_grp;
        jj      = k_ext & (span - LOG_N'(1));
        grp     = k_ext >> sh_grp;
        base    = grp << sh_base;
        addr0   = base | jj;
        addr1   = addr0 + span;
        tw      = jj[KW-1:0] << stage_q;
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        stage_d     = stage_q;
        cnt_d       = cnt_q;
        rd_en_d     = 1'b0;
        rd_addr0_d  = '0;
        rd_addr1_d  = '0;
        tw_addr_d   = '0;
        stage_out_d = stage_q;
        busy_d      = (state_q != S_IDLE);
        done_d      = (state_q == S_DONE);

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    k_d     = '0;
                    stage_d = '0;
                end
            end
            S_RUN: begin
                if (!stall_eff) begin
                    rd_en_d    = 1'b1;
                    rd_addr0_d = addr0;
                    rd_addr1_d = addr1;
                    tw_addr_d  = tw;
                    k_d        = k_q + KW'(1);
                    if (k_q == '1) begin
                        state_d = S_DRAIN;
                        cnt_d   = '0;
                    end
                end
            end
            S_DRAIN: begin
                // The last write of this stage lands before the next stage's first read.
                if (cnt_q == CW'(LAT - 1)) begin
                    cnt_d = '0;
                    if (stage_q == SW'(LOG_N - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                        stage_d = stage_q + SW'(1);
                        k_d     = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            stage_q     <= '0;
            cnt_q       <= '0;
            rd_en_q     <= 1'b0;
            rd_addr0_q  <= '0;
            rd_addr1_q  <= '0;
            tw_addr_q   <= '0;
            stage_out_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < LAT; i++) begin
                dly_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            stage_q     <= stage_d;
            cnt_q       <= cnt_d;
            rd_en_q     <= rd_en_d;
            rd_addr0_q  <= rd_addr0_d;
            rd_addr1_q  <= rd_addr1_d;
            tw_addr_q   <= tw_addr_d;
            stage_out_q <= stage_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dly_q[0]    <= {rd_en_q, rd_addr0_q, rd_addr1_q};
            for (int i = 1; i < LAT; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    assign rd_en_o    = rd_en_q;
    assign rd_addr0_o = rd_addr0_q;
    assign rd_addr1_o = rd_addr1_q;
    assign tw_addr_o  = tw_addr_q;
    assign stage_o    = stage_out_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign wr_en_o    = dly_q[LAT-1][DW-1];
    assign wr_addr0_o = dly_q[LAT-1][2*LOG_N-1:LOG_N];
    assign wr_addr1_o = dly_q[LAT-1][LOG_N-1:0];

endmodule

// File: tb/tb_fft_bf_sequencer.sv
// Scoreboard bench for fft_bf_sequencer at LOG_N=3, LAT=3 with hand-computed read/write schedules.
module tb_fft_bf_sequencer;

    logic       clock_i = 1'b0;
    logic       reset_i;
    logic       start_i;
    logic       stall_i;
    logic       rd_en_o;
    logic [2:0] rd_addr0_o, rd_addr1_o;
    logic [1:0] tw_addr_o;
    logic       wr_en_o;
    logic [2:0] wr_addr0_o, wr_addr1_o;
    logic [1:0] stage_o;
    logic       busy_o;
    logic       done_o;

    fft_bf_sequencer #(.LOG_N(3), .LAT(3)) dut (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .start_i    (start_i),
        .stall_i    (stall_i),
        .rd_en_o    (rd_en_o),
        .rd_addr0_o (rd_addr0_o),
        .rd_addr1_o (rd_addr1_o),
        .tw_addr_o  (tw_addr_o),
        .wr_en_o    (wr_en_o),
        .wr_addr0_o (wr_addr0_o),
        .wr_addr1_o (wr_addr1_o),
        .stage_o    (stage_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    always #5 clock_i = ~clock_i;

    int cyc = 0;
    always @(posedge clock_i) cyc <= cyc + 1;

    typedef struct {
        int c;
        int a0;
        int a1;
        int tw;
        int st;
    } exp_t;

    exp_t rd_exp[$];
    exp_t wr_exp[$];
    int   done_exp[$];
    int   hz_c[$];
    int   hz_a[$];

    int n_vec = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    // Operand pairs and twiddles for N=8, in issue order (stage 0, 1, 2).
    int A0_T[12] = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
    int A1_T[12] = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
    int TW_T[12] = '{0, 1, 2, 3, 0, 2, 0, 2, 0, 0, 0, 0};
    int RC_B[12] = '{1, 2, 3, 4, 8, 9, 10, 11, 15, 16, 17, 18};
    localparam int DONE_B = 22;
`ifdef FFT_SEQ_STALL_EN
    int RC_S[12] = '{1, 4, 5, 6, 10, 11, 12, 13, 17, 18, 19, 20};
    localparam int DONE_S = 24;
`else
    int RC_S[12] = '{1, 2, 3, 4, 8, 9, 10, 11, 15, 16, 17, 18};
    localparam int DONE_S = 22;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0d, want %0d", name, cyc, act, exp);
        end
    endtask

    task automatic flag(input string name, input int c);
        n_vec++;
        n_err++;
        $display("FAIL %s @cycle %0d (expected cycle %0d)", name, cyc, c);
    endtask

    task automatic push_xfer(input int t0, input bit stalled, input int cut);
        exp_t x;
        int   rc;
        for (int i = 0; i < 12; i++) begin
            rc   = t0 + (stalled ? RC_S[i] : RC_B[i]);
            x.a0 = A0_T[i];
            x.a1 = A1_T[i];
            x.tw = TW_T[i];
            x.st = i / 4;
            if (rc < cut) begin
                x.c = rc;
                rd_exp.push_back(x);
            end
            if (rc + 3 < cut) begin
                x.c = rc + 3;
                wr_exp.push_back(x);
            end
        end
        rc = t0 + (stalled ? DONE_S : DONE_B);
        if (rc < cut) done_exp.push_back(rc);
    endtask

    exp_t e_rd, e_wr;
    int   d_c;
    int   hz_cnt;

    always @(negedge clock_i) begin
        if (mon_en) begin
            while (rd_exp.size() > 0 && rd_exp[0].c < cyc) begin
                e_rd = rd_exp.pop_front();
                flag("rd_missing", e_rd.c);
            end
            while (wr_exp.size() > 0 && wr_exp[0].c < cyc) begin
                e_wr = wr_exp.pop_front();
                flag("wr_missing", e_wr.c);
            end
            while (done_exp.size() > 0 && done_exp[0] < cyc) begin
                d_c = done_exp.pop_front();
                flag("done_missing", d_c);
            end

            if (rd_en_o === 1'b1) begin
                if (rd_exp.size() == 0 || rd_exp[0].c != cyc) begin
                    flag("rd_unexpected", cyc);
                end else begin
                    e_rd = rd_exp.pop_front();
                    chk("rd_addr0", rd_addr0_o, e_rd.a0);
                    chk("rd_addr1", rd_addr1_o, e_rd.a1);
                    chk("tw_addr", tw_addr_o, e_rd.tw);
                    chk("stage", stage_o, e_rd.st);
                end
                hz_cnt = 0;
                foreach (hz_c[i]) begin
                    if (hz_c[i] >= cyc - 3 &&
                        (hz_a[i] == int'(rd_addr0_o) || hz_a[i] == int'(rd_addr1_o)))
                        hz_cnt++;
                end
                chk("rd_raw_hazard", hz_cnt, 0);
                hz_c.push_back(cyc); hz_a.push_back(int'(rd_addr0_o));
                hz_c.push_back(cyc); hz_a.push_back(int'(rd_addr1_o));
                while (hz_c.size() > 0 && hz_c[0] < cyc - 3) begin
                    void'(hz_c.pop_front());
                    void'(hz_a.pop_front());
                end
            end else begin
                chk("rd_idle_zero", {rd_en_o, rd_addr0_o, rd_addr1_o, tw_addr_o}, 0);
            end

            if (wr_en_o === 1'b1) begin
                if (wr_exp.size() == 0 || wr_exp[0].c != cyc) begin
                    flag("wr_unexpected", cyc);
                end else begin
                    e_wr = wr_exp.pop_front();
                    chk("wr_addr0", wr_addr0_o, e_wr.a0);
                    chk("wr_addr1", wr_addr1_o, e_wr.a1);
                end
            end else if (wr_en_o !== 1'b0) begin
                flag("wr_en_unknown", cyc);
            end

            if (done_o === 1'b1) begin
                if (done_exp.size() == 0 || done_exp[0] != cyc) begin
                    flag("done_unexpected", cyc);
                end else begin
                    d_c = done_exp.pop_front();
                    chk("done_busy", busy_o, 1);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clock_i);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clock_i);
    endtask

    int t0, t1;

    initial begin
        reset_i = 1'b1;
        start_i = 1'b1;
        stall_i = 1'b0;
        repeat (3) tick();
        reset_i = 1'b0;
        start_i = 1'b0;
        tick();
        chk("reset_outputs",
            {rd_en_o, wr_en_o, busy_o, done_o, stage_o, rd_addr0_o, rd_addr1_o,
             tw_addr_o, wr_addr0_o, wr_addr1_o}, 0);
        mon_en = 1'b1;
        repeat (4) tick();
        chk("start_with_reset_ignored", busy_o, 0);

        // Basic transform, starts while busy, then back-to-back restart after done.
        t0 = cyc + 1;
        start_i = 1'b1;
        push_xfer(t0, 1'b0, 1 << 30);
        tick();
        start_i = 1'b0;
        chk("busy_cycle0", busy_o, 0);
        tick();
        chk("busy_cycle1", busy_o, 1);
        wait_until(t0 + 4);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_until(t0 + 21);
        start_i = 1'b1;
        tick();
        t1 = t0 + 23;
        push_xfer(t1, 1'b0, 1 << 30);
        tick();
        start_i = 1'b0;
        chk("busy_after_done", busy_o, 0);
        wait_until(t1 + 30);

        // Stall sampled on relative cycles 2 and 3.
        t0 = cyc + 1;
        start_i = 1'b1;
        push_xfer(t0, 1'b1, 1 << 30);
        tick();
        start_i = 1'b0;
        wait_until(t0 + 1);
        stall_i = 1'b1;
        tick();
        tick();
        stall_i = 1'b0;
        wait_until(t0 + 30);

        // Reset sampled at relative cycle 10 cancels everything still in flight.
        t0 = cyc + 1;
        start_i = 1'b1;
        push_xfer(t0, 1'b0, t0 + 10);
        tick();
        start_i = 1'b0;
        wait_until(t0 + 9);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        chk("mid_reset_outputs",
            {rd_en_o, wr_en_o, busy_o, done_o, stage_o, rd_addr0_o, rd_addr1_o,
             tw_addr_o, wr_addr0_o, wr_addr1_o}, 0);
        repeat (15) tick();
        chk("idle_after_reset", busy_o, 0);

        t0 = cyc + 1;
        start_i = 1'b1;
        push_xfer(t0, 1'b0, 1 << 30);
        tick();
        start_i = 1'b0;
        wait_until(t0 + 30);

        chk("rd_queue_drained", rd_exp.size(), 0);
        chk("wr_queue_drained", wr_exp.size(), 0);
        chk("done_queue_drained", done_exp.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
